// File: rtl/pe_window_spad.sv
// rtl/pe_window_spad.sv - sliding-window circular scratchpad with head-relative reads and multi-entry pop
module pe_window_spad #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int NUM_RD  = 2,
  parameter int MAX_POP = 4,
  parameter int RD_LAT  = 0
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]          rd_data,
  output logic [NUM_RD-1:0]                 rd_oob,
  input  logic                              pop_en,
  input  logic [$clog2(MAX_POP+1)-1:0]      pop_num,
  output logic                              pop_err,
  input  logic                              clear,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_err_q, pop_err_d;
  logic              wr_acc, pop_req;
  logic [SW-1:0]     count_s, pop_s, pop_cnt, head_sum;

  assign count_s  = SW'(count_q);
  assign pop_s    = SW'(pop_num);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full && !clear;
  assign wr_acc   = wr_valid && wr_ready;
  assign pop_req  = pop_en && (pop_num != '0) && !clear;
  assign count    = count_q;
  assign pop_err  = pop_err_q;

  // Pop count is clamped to the occupancy seen at the start of the cycle.
  always_comb begin
    pop_cnt = '0;
    if (pop_req) pop_cnt = (pop_s > count_s) ? count_s : pop_s;
    head_sum  = {1'b0, head_q} + pop_cnt;
    head_d    = (head_sum >= DEPTH_S) ? AW'(head_sum - DEPTH_S) : head_sum[AW-1:0];
    tail_d    = tail_q;
    if (wr_acc) tail_d = (tail_q == AW'(DEPTH-1)) ? '0 : tail_q + AW'(1);
    count_d   = CW'(count_s + SW'(wr_acc) - pop_cnt);
    pop_err_d = pop_req && (pop_s > count_s);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pop_err_q <= pop_err_d;
      if (wr_acc) mem_q[tail_q] <= wr_data;
    end
  end

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_oob_c;
  logic [SW-1:0]            addr_s, phys_s;

  // An in-range offset keeps head+offset below 2*DEPTH, so one subtract suffices.
  always_comb begin
    rd_data_c = '0;
    rd_oob_c  = '0;
    addr_s    = '0;
    phys_s    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr_s = {1'b0, rd_addr[i*AW +: AW]};
      phys_s = {1'b0, head_q} + addr_s;
      if (phys_s >= DEPTH_S) phys_s = phys_s - DEPTH_S;
      rd_oob_c[i] = (addr_s >= count_s);
      if (!rd_oob_c[i]) rd_data_c[i*DATA_W +: DATA_W] = mem_q[phys_s[AW-1:0]];
    end
  end

  if (RD_LAT == 1) begin : g_rd_reg
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]        rd_oob_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        rd_data_q <= '0;
        rd_oob_q  <= '1;
      end else begin
        rd_data_q <= rd_data_c;
        rd_oob_q  <= rd_oob_c;
      end
    end
    assign rd_data = rd_data_q;
    assign rd_oob  = rd_oob_q;
  end else begin : g_rd_comb
    assign rd_data = rd_data_c;
    assign rd_oob  = rd_oob_c;
  end
endmodule
